// File: rtl/game_cmd_ctrl.sv
// game_cmd_ctrl: turns raw start/stop push-buttons into the one-cycle en
// strobe and 2-bit func code consumed by the game state register.
// Each button passes through a 2-FF synchroniser, a counter debouncer and a
// rising-edge detector. A 2-state FSM drops illegal commands.
// Optional feature: define GAME_CMD_HOLDOFF_EN to build a lockout counter
// that ignores all presses for HOLDOFF_CYCLES cycles after each command.
module game_cmd_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLDOFF_CYCLES  = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_stop,
   output logic       en,
   output logic [1:0] func,
   output logic       running
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] FUNC_NONE  = 2'b00;
   localparam logic [1:0] FUNC_START = 2'b01;
   localparam logic [1:0] FUNC_END   = 2'b10;

   // Bit 0 carries the start button, bit 1 the stop button throughout.
   localparam int B_START = 0;
   localparam int B_STOP  = 1;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RUNNING = 1'b1
   } state_t;

   // Reject a debounce length that would make the counter compare meaningless.
   if (DEBOUNCE_CYCLES < 1 || HOLDOFF_CYCLES < 0) begin : g_bad_param
      $error("game_cmd_ctrl: DEBOUNCE_CYCLES must be >= 1 and HOLDOFF_CYCLES >= 0");
   end

   logic [1:0]       w_btn;
   logic [1:0]       r_s1;
   logic [1:0]       r_s2;
   logic [1:0]       r_stable;
   logic [1:0]       r_stable_d;
   logic [CNT_W-1:0] r_cnt [2];
   logic [1:0]       w_press;
   logic             w_hold_busy;
   logic             w_accept;
   state_t           r_state;
   logic             r_en;
   logic [1:0]       r_func;

   assign w_btn = {btn_stop, btn_start};

   // Synchronise, debounce and delay both buttons in lockstep.
   always_ff @(posedge clk) begin
      // NOTE: every clocked assignment is non-blocking so all flops sample
      // the pre-edge values and the s1->s2->stable chain shifts correctly.
      if (rst) begin
         r_s1       <= '0;
         r_s2       <= '0;
         r_stable   <= '0;
         r_stable_d <= '0;
         for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
      end else begin
         r_s1       <= w_btn;
         r_s2       <= r_s1;
         r_stable_d <= r_stable;
         for (int i = 0; i < 2; i++) begin
            if (r_s2[i] == r_stable[i]) begin
               // Any return to the accepted level restarts the count.
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_stable[i] <= r_s2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Rising edges of the debounced level only; releases never issue commands.
   assign w_press = r_stable & ~r_stable_d;

`ifdef GAME_CMD_HOLDOFF_EN
   localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

   logic [HOLD_W-1:0] r_hold;

   assign w_hold_busy = (r_hold != '0);

   // Lockout counter: loaded by each accepted command, counts down to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold <= '0;
      end else if (w_accept) begin
         r_hold <= HOLD_W'(HOLDOFF_CYCLES);
      end else if (w_hold_busy) begin
         r_hold <= r_hold - HOLD_W'(1);
      end
   end
`else
   assign w_hold_busy = 1'b0;
`endif

   // A press is legal when it changes the game state; a simultaneous
   // start+stop counts as stop only, so it does nothing in IDLE.
   assign w_accept = !w_hold_busy &&
                     (((r_state == ST_IDLE)    && w_press[B_START] && !w_press[B_STOP]) ||
                      ((r_state == ST_RUNNING) && w_press[B_STOP]));

   // Game FSM with registered strobe and command code.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_en    <= 1'b0;
         r_func  <= FUNC_NONE;
      end else begin
         r_en   <= 1'b0;
         r_func <= FUNC_NONE;
         if (w_accept) begin
            r_en <= 1'b1;
            if (r_state == ST_IDLE) begin
               r_func  <= FUNC_START;
               r_state <= ST_RUNNING;
            end else begin
               r_func  <= FUNC_END;
               r_state <= ST_IDLE;
            end
         end
      end
   end

   assign en      = r_en;
   assign func    = r_func;
   assign running = (r_state == ST_RUNNING);

endmodule

// File: tb/tb_game_cmd_ctrl.sv
// Testbench for game_cmd_ctrl with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8.
// Honours GAME_CMD_HOLDOFF_EN the same way the design does.
module tb_game_cmd_ctrl;

   localparam int D = 4;
   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_start;
   logic       btn_stop;
   logic       en;
   logic [1:0] func;
   logic       running;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       rst;
      logic       bs;
      logic       bp;
      logic       en;
      logic [1:0] func;
      logic       run;
   } vec_t;

   vec_t vecs[$];

   game_cmd_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .HOLDOFF_CYCLES (H)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_start(btn_start),
      .btn_stop (btn_stop),
      .en       (en),
      .func     (func),
      .running  (running)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic r, input logic bs, input logic bp,
                       input logic e, input logic [1:0] f, input logic run);
      vec_t v;
      v.tag = tag; v.rst = r; v.bs = bs; v.bp = bp; v.en = e; v.func = f; v.run = run;
      vecs.push_back(v);
   endtask

   // n quiet cycles (no strobe expected) with the given inputs and state.
   task automatic push_run(input string tag, input int n, input logic r, input logic bs,
                           input logic bp, input logic run);
      for (int i = 0; i < n; i++) push(tag, r, bs, bp, 1'b0, 2'b00, run);
   endtask

   // Button held 8 cycles, released 8 cycles; pulse lands on the 7th edge.
   task automatic push_press(input string tag, input logic bs, input logic bp,
                             input logic run_before, input logic e,
                             input logic [1:0] f, input logic run_after);
      push_run(tag, D + 2, 1'b0, bs, bp, run_before);
      push(tag, 1'b0, bs, bp, e, f, run_after);
      push_run(tag, 1, 1'b0, bs, bp, run_after);
      push_run(tag, 8, 1'b0, 1'b0, 1'b0, run_after);
   endtask

   initial begin
      logic hold_run;
      int   edges;
      bit   seen;

      rst       = 1'b1;
      btn_start = 1'b0;
      btn_stop  = 1'b0;

      // Reset, then a long quiet interval.
      push_run("reset", 2, 1'b1, 1'b0, 1'b0, 1'b0);
      push_run("idle", 20, 1'b0, 1'b0, 1'b0, 1'b0);

      // Bounce: 2-cycle high runs never satisfy a 4-sample debounce.
      for (int k = 0; k < 3; k++) begin
         push_run("bounce", 2, 1'b0, 1'b1, 1'b0, 1'b0);
         push_run("bounce", 2, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      push_run("bounce", 8, 1'b0, 1'b0, 1'b0, 1'b0);

      // Clean start: 12 cycles high, single strobe on edge 7.
      push_run("clean_start", 6, 1'b0, 1'b1, 1'b0, 1'b0);
      push("clean_start", 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
      push_run("clean_start", 5, 1'b0, 1'b1, 1'b0, 1'b1);
      push_run("clean_start", 8, 1'b0, 1'b0, 1'b0, 1'b1);

      // Start while running is dropped; stop is accepted.
      push_press("illegal_start", 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      push_press("stop",          1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
      // Stop while idle is dropped.
      push_press("illegal_stop",  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      push_press("restart",       1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1);
      // Both buttons together while running: stop only.
      push_press("simul_run",     1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
      // Both buttons together while idle: nothing.
      push_press("simul_idle",    1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      push_press("restart2",      1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1);

      // Holdoff: stop pulse at idx 6, start pulse 3 cycles later at idx 9.
`ifdef GAME_CMD_HOLDOFF_EN
      hold_run = 1'b0;
`else
      hold_run = 1'b1;
`endif
      push_run("holdoff", 3, 1'b0, 1'b0, 1'b1, 1'b1);
      push_run("holdoff", 3, 1'b0, 1'b1, 1'b1, 1'b1);
      push("holdoff", 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
      push_run("holdoff", 1, 1'b0, 1'b1, 1'b1, 1'b0);
      push_run("holdoff", 1, 1'b0, 1'b1, 1'b0, 1'b0);
      push("holdoff", 1'b0, 1'b1, 1'b0, hold_run, hold_run ? 2'b01 : 2'b00, hold_run);
      push_run("holdoff", 1, 1'b0, 1'b1, 1'b0, hold_run);
      push_run("holdoff", 9, 1'b0, 1'b0, 1'b0, hold_run);

      foreach (vecs[i]) begin
         rst       = vecs[i].rst;
         btn_start = vecs[i].bs;
         btn_stop  = vecs[i].bp;
         tick();
         check($sformatf("%s[%0d] {en,func,running}", vecs[i].tag, i),
               {29'd0, en, func, running},
               {29'd0, vecs[i].en, vecs[i].func, vecs[i].run});
      end

      // Reset mid-debounce: start held 2 cycles, rst pulsed, button kept high.
      btn_start = 1'b1;
      btn_stop  = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("mid_rst outputs", {29'd0, en, func, running}, 32'd0);
      rst   = 1'b0;
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 20) begin
         tick();
         edges++;
         if (en === 1'b1) seen = 1'b1;
      end
      check("mid_rst en seen", {31'd0, seen}, 32'd1);
      check("mid_rst en edge", edges, D + 3);
      check("mid_rst func/running", {29'd0, en, func, running}, {29'd0, 1'b1, 2'b01, 1'b1});
      tick();
      check("mid_rst en one cycle", {29'd0, en, func, running}, {29'd0, 1'b0, 2'b00, 1'b1});

      btn_start = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
